// File: rtl/arcade_pkg.sv
// Shared types and constants for the whack-a-mole arcade datapath.
package arcade_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, SHOW, GAP, DONE} round_state_t;

  localparam int N_HOLES = 9;
  localparam int NUM_MIN = 1;
  localparam int NUM_MAX = 9;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // idx must already be in 0..N_HOLES-1.
  function automatic logic [N_HOLES-1:0] hole_onehot(input logic [7:0] idx);
    return N_HOLES'(1) << idx;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that sticks at zero; zero flag is combinational from the count.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: fetch a hole, show it until press or timeout, score, gap, repeat.
// Registered outputs; start->FETCH +1 cycle, LED +2 cycles, hit visible on score the cycle after the press.
module mole_round_ctrl
  import arcade_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int GAP_CYC     = 10_000_000,
  parameter int ROUNDS      = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         random_num,
  input  logic               start,
  input  logic [N_HOLES-1:0] btn,
  output logic [N_HOLES-1:0] target_led,
  output logic [7:0]         score,
  output logic [7:0]         miss,
  output logic [7:0]         round_cnt,
  output logic               game_over,
  output logic               busy
);

  localparam int TMAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  round_state_t  state;
  logic          num_ok;
  logic          hit;
  logic          wrong;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic [7:0]    rnd_next;

  cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // target_led doubles as the latched target mask while in SHOW.
  always_comb begin
    num_ok   = (random_num >= 8'(NUM_MIN)) && (random_num <= 8'(NUM_MAX));
    hit      = |(btn & target_led);
    wrong    = |(btn & ~target_led);
    rnd_next = sat_inc(round_cnt);
    tmr_load = 1'b0;
    tmr_val  = TW'(GAP_CYC - 1);
    case (state)
      FETCH: if (num_ok) begin
        tmr_load = 1'b1;
        tmr_val  = TW'(TIMEOUT_CYC - 1);
      end
      SHOW:    tmr_load = hit || wrong || tmr_zero;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      target_led <= '0;
      score      <= '0;
      miss       <= '0;
      round_cnt  <= '0;
      game_over  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          score     <= '0;
          miss      <= '0;
          round_cnt <= '0;
          game_over <= 1'b0;
          busy      <= 1'b1;
          state     <= FETCH;
        end
        FETCH: if (num_ok) begin
          target_led <= hole_onehot(random_num - 8'd1);
          state      <= SHOW;
        end
        SHOW: begin
          // Correct hole beats any stray bits; a press on the last cycle beats the timeout.
          if (hit)
            score <= sat_inc(score);
          else if (wrong || tmr_zero)
            miss <= sat_inc(miss);
          if (hit || wrong || tmr_zero) begin
            target_led <= '0;
            state      <= GAP;
          end
        end
        GAP: if (tmr_zero) begin
          round_cnt <= rnd_next;
          if (rnd_next == 8'(ROUNDS)) begin
            busy      <= 1'b0;
            game_over <= 1'b1;
            state     <= DONE;
          end else begin
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed bench for mole_round_ctrl with short timeout/gap and a 3-round game.
module tb_mole_round_ctrl;

  localparam int T = 8;
  localparam int G = 4;
  localparam int R = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] random_num = 8'd0;
  logic [8:0] btn = 9'd0;
  logic [8:0] target_led;
  logic [7:0] score, miss, round_cnt;
  logic       game_over, busy;

  always #5 clk = ~clk;

  mole_round_ctrl #(.TIMEOUT_CYC(T), .GAP_CYC(G), .ROUNDS(R)) dut (
    .clk        (clk),
    .rst        (rst),
    .random_num (random_num),
    .start      (start),
    .btn        (btn),
    .target_led (target_led),
    .score      (score),
    .miss       (miss),
    .round_cnt  (round_cnt),
    .game_over  (game_over),
    .busy       (busy)
  );

  typedef struct packed {
    logic [8:0] led;
    logic [7:0] score;
    logic [7:0] miss;
    logic [7:0] rnd;
    logic       go;
    logic       busy;
  } out_t;

  typedef struct {
    logic       r;
    logic       s;
    logic [7:0] n;
    logic [8:0] b;
    out_t       e;
  } vec_t;

  vec_t vecs[14];
  int   n_run  = 0;
  int   n_fail = 0;
  int   lit;

  function automatic out_t mk(input logic [8:0] led, input logic [7:0] sc, input logic [7:0] ms,
                              input logic [7:0] rn, input logic go, input logic bz);
    out_t o;
    o.led = led; o.score = sc; o.miss = ms; o.rnd = rn; o.go = go; o.busy = bz;
    return o;
  endfunction

  function automatic vec_t mv(input logic r, input logic s, input logic [7:0] n,
                              input logic [8:0] b, input out_t e);
    vec_t v;
    v.r = r; v.s = s; v.n = n; v.b = b; v.e = e;
    return v;
  endfunction

  // Inputs are applied just after an edge; outputs are sampled 1 unit after the next edge.
  task automatic drive(input logic r, input logic s, input logic [7:0] n, input logic [8:0] b);
    rst = r; start = s; random_num = n; btn = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input out_t e);
    out_t a;
    a = mk(target_led, score, miss, round_cnt, game_over, busy);
    n_run++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got led=%b score=%0d miss=%0d rnd=%0d go=%b busy=%b, want led=%b score=%0d miss=%0d rnd=%0d go=%b busy=%b",
               nm, a.led, a.score, a.miss, a.rnd, a.go, a.busy,
               e.led, e.score, e.miss, e.rnd, e.go, e.busy);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  initial begin
    // Reset held with start/random asserted, idle after release, then one hit round.
    vecs[0]  = mv(1, 1, 5, 9'h000, mk(9'h000, 0, 0, 0, 0, 0));
    vecs[1]  = mv(1, 1, 5, 9'h000, mk(9'h000, 0, 0, 0, 0, 0));
    vecs[2]  = mv(1, 1, 5, 9'h000, mk(9'h000, 0, 0, 0, 0, 0));
    vecs[3]  = mv(0, 0, 5, 9'h000, mk(9'h000, 0, 0, 0, 0, 0));
    vecs[4]  = mv(0, 0, 5, 9'h000, mk(9'h000, 0, 0, 0, 0, 0));
    vecs[5]  = mv(0, 1, 5, 9'h000, mk(9'h000, 0, 0, 0, 0, 1));
    vecs[6]  = mv(0, 0, 5, 9'h000, mk(9'h010, 0, 0, 0, 0, 1));
    vecs[7]  = mv(0, 0, 5, 9'h000, mk(9'h010, 0, 0, 0, 0, 1));
    vecs[8]  = mv(0, 0, 5, 9'h000, mk(9'h010, 0, 0, 0, 0, 1));
    vecs[9]  = mv(0, 0, 5, 9'h010, mk(9'h000, 1, 0, 0, 0, 1));
    vecs[10] = mv(0, 0, 0, 9'h000, mk(9'h000, 1, 0, 0, 0, 1));
    vecs[11] = mv(0, 0, 0, 9'h000, mk(9'h000, 1, 0, 0, 0, 1));
    vecs[12] = mv(0, 0, 0, 9'h000, mk(9'h000, 1, 0, 0, 0, 1));
    vecs[13] = mv(0, 0, 0, 9'h000, mk(9'h000, 1, 0, 1, 0, 1));

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].n, vecs[i].b);
      chk($sformatf("vec%0d", i), vecs[i].e);
    end

    // Invalid random numbers keep the controller waiting in FETCH.
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 9'h000);
      chk("fetch_hold", mk(9'h000, 1, 0, 1, 0, 1));
    end
    drive(0, 0, 9, 9'h000);
    chk("lit_hole8", mk(9'h100, 1, 0, 1, 0, 1));

    // Press on the final (timer==0) cycle counts as a hit.
    for (int i = 0; i < T - 1; i++) begin
      drive(0, 0, 0, 9'h000);
      chk("show_hole8", mk(9'h100, 1, 0, 1, 0, 1));
    end
    drive(0, 0, 0, 9'h100);
    chk("last_cycle_hit", mk(9'h000, 2, 0, 1, 0, 1));

    drive(0, 0, 0, 9'h1FF);
    chk("gap_ignores_btn", mk(9'h000, 2, 0, 1, 0, 1));
    drive(0, 0, 0, 9'h000);
    drive(0, 0, 0, 9'h000);
    drive(0, 0, 0, 9'h000);
    chk("round2_fetch", mk(9'h000, 2, 0, 2, 0, 1));

    // Timeout round: count lit cycles until the target goes dark.
    drive(0, 0, 3, 9'h000);
    chk("lit_hole2", mk(9'h004, 2, 0, 2, 0, 1));
    lit = 1;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 9'h000);
      if (target_led == 9'h004) lit++;
      else break;
    end
    chk_int("lit_cycles", lit, T);
    chk("timeout_miss", mk(9'h000, 2, 1, 2, 0, 1));

    for (int i = 0; i < G - 1; i++) begin
      drive(0, 0, 0, 9'h000);
      chk("gap3", mk(9'h000, 2, 1, 2, 0, 1));
    end
    drive(0, 0, 0, 9'h000);
    chk("game_over", mk(9'h000, 2, 1, 3, 1, 0));
    drive(0, 0, 5, 9'h010);
    chk("done_hold", mk(9'h000, 2, 1, 3, 1, 0));
    drive(0, 1, 5, 9'h000);
    chk("restart", mk(9'h000, 0, 0, 0, 0, 1));

    // Second game: hit wins over stray bits, then a wrong press.
    drive(0, 0, 3, 9'h000);
    chk("g2_lit", mk(9'h004, 0, 0, 0, 0, 1));
    drive(0, 0, 0, 9'h000);
    drive(0, 0, 0, 9'h005);
    chk("hit_wins", mk(9'h000, 1, 0, 0, 0, 1));
    for (int i = 0; i < G; i++) drive(0, 0, 0, 9'h000);
    chk("g2_round1", mk(9'h000, 1, 0, 1, 0, 1));
    drive(0, 0, 3, 9'h000);
    drive(0, 0, 0, 9'h001);
    chk("wrong_btn", mk(9'h000, 1, 1, 1, 0, 1));
    for (int i = 0; i < G; i++) drive(0, 0, 0, 9'h000);
    chk("g2_round2", mk(9'h000, 1, 1, 2, 0, 1));

    // Reset in the middle of SHOW.
    drive(0, 0, 3, 9'h000);
    chk("g2_lit3", mk(9'h004, 1, 1, 2, 0, 1));
    drive(0, 0, 0, 9'h000);
    drive(1, 0, 0, 9'h000);
    chk("mid_reset", mk(9'h000, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 5, 9'h004);
      chk("idle_ignores_btn", mk(9'h000, 0, 0, 0, 0, 0));
    end
    drive(0, 1, 5, 9'h000);
    chk("start_after_reset", mk(9'h000, 0, 0, 0, 0, 1));
    drive(0, 0, 5, 9'h000);
    chk("lit_after_reset", mk(9'h010, 0, 0, 0, 0, 1));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
